// File: rtl/ahblite_interconnect_n.sv
// AHB-Lite address decoder and slave-response mux with a built-in default slave.
// Define AHB_DECODER_ERRLOG_EN to add a sticky log of the first unmapped address.
module ahblite_interconnect_n #(
  parameter int unsigned            PORT_NUM  = 8,
  parameter logic [15:0]            PORT_EN   = 16'h00FF,
  parameter logic [16*PORT_NUM-1:0] BASE_ADDR = {16'h4005, 16'h4004, 16'h4003, 16'h4002,
                                                 16'h4001, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [16*PORT_NUM-1:0] ADDR_MASK = {PORT_NUM{16'hFFFF}}
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HRESP,
  output logic [PORT_NUM-1:0]      P_HSEL,
  input  logic [32*PORT_NUM-1:0]   P_HRDATA,
  input  logic [PORT_NUM-1:0]      P_HREADYOUT,
  input  logic [PORT_NUM-1:0]      P_HRESP
`ifdef AHB_DECODER_ERRLOG_EN
  ,
  input  logic                     ERR_CLR,
  output logic                     ERR_VALID,
  output logic [31:0]              ERR_ADDR
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

  state_t              r_state;
  logic                r_def_ready;
  logic                r_def_resp;
  logic [PORT_NUM:0]   r_dsel;

  logic [PORT_NUM-1:0] w_hsel;
  logic                w_found;
  logic                w_default_hit;
  logic                w_hready;
  logic                w_hresp;
  logic [31:0]         w_hrdata;
  logic                w_err_req;

  // Lowest matching index wins, keeping the select one-hot.
  always_comb begin
    w_hsel  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (!w_found && PORT_EN[i] &&
          ((HADDR[31:16] & ADDR_MASK[16*i +: 16]) ==
           (BASE_ADDR[16*i +: 16] & ADDR_MASK[16*i +: 16]))) begin
        w_hsel[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  assign w_default_hit = ~|w_hsel;
  assign P_HSEL        = w_hsel;

  always_comb begin
    w_hrdata = '0;
    w_hready = r_def_ready;
    w_hresp  = r_def_resp;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (r_dsel[i]) begin
        w_hrdata = P_HRDATA[32*i +: 32];
        w_hready = P_HREADYOUT[i];
        w_hresp  = P_HRESP[i];
      end
    end
  end

  assign HREADY = w_hready;
  assign HRESP  = w_hresp;
  assign HRDATA = w_hrdata;

  assign w_err_req = w_hready & w_default_hit & HTRANS[1];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dsel <= {1'b1, {PORT_NUM{1'b0}}};
    end else if (w_hready) begin
      r_dsel <= {w_default_hit, w_hsel};
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_def_ready <= 1'b1;
      r_def_resp  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_err_req) begin
            r_state     <= S_ERR1;
            r_def_ready <= 1'b0;
            r_def_resp  <= 1'b1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_def_ready <= 1'b1;
          r_def_resp  <= 1'b1;
        end
        S_ERR2: begin
          if (w_err_req) begin
            r_state     <= S_ERR1;
            r_def_ready <= 1'b0;
            r_def_resp  <= 1'b1;
          end else begin
            r_state     <= S_IDLE;
            r_def_ready <= 1'b1;
            r_def_resp  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_def_ready <= 1'b1;
          r_def_resp  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AHB_DECODER_ERRLOG_EN
  logic        r_err_valid;
  logic [31:0] r_err_addr;

  // A new error overrides a same-cycle clear; otherwise the first logged address is kept.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_err_req && (r_state != S_ERR1)) begin
      if (!r_err_valid || ERR_CLR) begin
        r_err_addr <= HADDR;
      end
      r_err_valid <= 1'b1;
    end else if (ERR_CLR) begin
      r_err_valid <= 1'b0;
    end
  end

  assign ERR_VALID = r_err_valid;
  assign ERR_ADDR  = r_err_addr;

  logic w_unused_trans;
  assign w_unused_trans = HTRANS[0];
`else
  // Low address bits and HTRANS[0] play no part in decode.
  logic w_unused_bits;
  assign w_unused_bits = ^{HADDR[15:0], HTRANS[0]};
`endif

endmodule

// File: tb/tb_ahblite_interconnect_n.sv
// Scoreboard bench for ahblite_interconnect_n: three instances (default map,
// port 2 disabled, overlapping port 3) share one master; AHB_DECODER_ERRLOG_EN adds log checks.
module tb_ahblite_interconnect_n;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [31:0] pdata [8];
  logic [255:0] p_hrdata;
  logic [7:0]  p_ready = 8'hFF;
  logic [7:0]  p_resp = 8'h00;

  logic        rdy_a, rdy_b, rdy_c, rsp_a, rsp_b, rsp_c;
  logic [31:0] dat_a, dat_b, dat_c;
  logic [7:0]  sel_a, sel_b, sel_c;
`ifdef AHB_DECODER_ERRLOG_EN
  logic        err_clr = 1'b0;
  logic        ev_a, ev_b, ev_c;
  logic [31:0] ea_a, ea_b, ea_c;
`endif

  always #5 HCLK = ~HCLK;

  always_comb begin
    p_hrdata = '0;
    for (int i = 0; i < 8; i++) p_hrdata[32*i +: 32] = pdata[i];
  end

  ahblite_interconnect_n dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(rdy_a), .HRDATA(dat_a), .HRESP(rsp_a), .P_HSEL(sel_a),
    .P_HRDATA(p_hrdata), .P_HREADYOUT(p_ready), .P_HRESP(p_resp)
`ifdef AHB_DECODER_ERRLOG_EN
    , .ERR_CLR(err_clr), .ERR_VALID(ev_a), .ERR_ADDR(ea_a)
`endif
  );

  ahblite_interconnect_n #(.PORT_EN(16'h00FB)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(rdy_b), .HRDATA(dat_b), .HRESP(rsp_b), .P_HSEL(sel_b),
    .P_HRDATA(p_hrdata), .P_HREADYOUT(p_ready), .P_HRESP(p_resp)
`ifdef AHB_DECODER_ERRLOG_EN
    , .ERR_CLR(err_clr), .ERR_VALID(ev_b), .ERR_ADDR(ea_b)
`endif
  );

  ahblite_interconnect_n #(
    .BASE_ADDR({16'h4005, 16'h4004, 16'h4003, 16'h4002, 16'h4000, 16'h4000, 16'h2000, 16'h0000}),
    .ADDR_MASK({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hF000, 16'hFFFF, 16'hFFFF, 16'hFFFF})
  ) dut_c (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(rdy_c), .HRDATA(dat_c), .HRESP(rsp_c), .P_HSEL(sel_c),
    .P_HRDATA(p_hrdata), .P_HREADYOUT(p_ready), .P_HRESP(p_resp)
`ifdef AHB_DECODER_ERRLOG_EN
    , .ERR_CLR(err_clr), .ERR_VALID(ev_c), .ERR_ADDR(ea_c)
`endif
  );

  // kind 0: P_HSEL, 1: HREADY/HRESP/HRDATA, 2: error log
  typedef struct {
    int          cyc;
    int          ph;
    int          dut;
    int          kind;
    logic [7:0]  sel;
    logic        rdy;
    logic        rsp;
    logic [31:0] dat;
    logic        v;
    string       name;
  } exp_t;

  exp_t sb [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic exp_sel(input int dc, input int dut, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.ph = 0; e.dut = dut; e.kind = 0; e.sel = v;
    e.rdy = 1'b0; e.rsp = 1'b0; e.dat = '0; e.v = 1'b0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_rsp(input int dc, input int ph, input int dut, input logic rdy,
                         input logic rsp, input logic [31:0] d, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.ph = ph; e.dut = dut; e.kind = 1; e.sel = '0;
    e.rdy = rdy; e.rsp = rsp; e.dat = d; e.v = 1'b0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_err(input int dc, input logic v, input logic [31:0] a, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.ph = 0; e.dut = 0; e.kind = 2; e.sel = '0;
    e.rdy = 1'b0; e.rsp = 1'b0; e.dat = a; e.v = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [7:0]  gs;
    logic        gr, gp;
    logic [31:0] gd;
    gs = (e.dut == 0) ? sel_a : (e.dut == 1) ? sel_b : sel_c;
    gr = (e.dut == 0) ? rdy_a : (e.dut == 1) ? rdy_b : rdy_c;
    gp = (e.dut == 0) ? rsp_a : (e.dut == 1) ? rsp_b : rsp_c;
    gd = (e.dut == 0) ? dat_a : (e.dut == 1) ? dat_b : dat_c;
    n_checks++;
    if (e.kind == 0) begin
      if (gs === e.sel) n_pass++;
      else $display("FAIL %s: P_HSEL got %h want %h", e.name, gs, e.sel);
    end else if (e.kind == 1) begin
      if (gr === e.rdy && gp === e.rsp && gd === e.dat) n_pass++;
      else $display("FAIL %s: got HREADY=%b HRESP=%b HRDATA=%h want HREADY=%b HRESP=%b HRDATA=%h",
                    e.name, gr, gp, gd, e.rdy, e.rsp, e.dat);
    end else begin
`ifdef AHB_DECODER_ERRLOG_EN
      if (ev_a === e.v && (!e.v || ea_a === e.dat)) n_pass++;
      else $display("FAIL %s: got ERR_VALID=%b ERR_ADDR=%h want ERR_VALID=%b ERR_ADDR=%h",
                    e.name, ev_a, ea_a, e.v, e.dat);
`else
      $display("FAIL %s: error-log expectation without error log", e.name);
`endif
    end
  endtask

  task automatic do_check(input int ph);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc && sb[i].ph == ph) begin
        compare(sb[i]);
        sb.delete(i);
      end
    end
  endtask

  // Monitor: phase 0 at the falling edge, phase 1 shortly before the next rising edge.
  initial begin
    forever begin
      @(negedge HCLK);
      do_check(0);
      #3;
      do_check(1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) pdata[i] = 32'hA000_0000 | i;
    pdata[0] = 32'h0000_C0DE;
    pdata[1] = 32'hDEAD_BEEF;
    pdata[2] = 32'h2222_2222;
    pdata[5] = 32'h5555_AAAA;

    step; step;
    exp_sel(0, 0, 8'h01, "rst_hsel");
    exp_rsp(0, 0, 0, 1'b1, 1'b0, 32'h0, "rst_resp");
`ifdef AHB_DECODER_ERRLOG_EN
    exp_err(0, 1'b0, 32'h0, "rst_errlog");
`endif
    step; HRESET = 1'b0;

    // mapped zero-wait read from port 1
    step; HADDR = 32'h2000_0010; HTRANS = 2'b10;
    exp_sel(0, 0, 8'h02, "t1_hsel");
    exp_rsp(1, 0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, "t1_rdata");
    step; HADDR = '0; HTRANS = 2'b00;

    // port 5 inserts three wait states while the next address is pending
    step; HADDR = 32'h4003_0000; HTRANS = 2'b10; p_ready[5] = 1'b0;
    exp_sel(0, 0, 8'h20, "t2_hsel5");
    exp_rsp(1, 0, 0, 1'b0, 1'b0, 32'h5555_AAAA, "t2_wait1");
    exp_rsp(2, 0, 0, 1'b0, 1'b0, 32'h5555_AAAA, "t2_wait2");
    exp_rsp(3, 0, 0, 1'b0, 1'b0, 32'h5555_AAAA, "t2_wait3");
    exp_rsp(4, 0, 0, 1'b1, 1'b0, 32'h5555_AAAA, "t2_done");
    exp_rsp(5, 0, 0, 1'b1, 1'b0, 32'h0000_C0DE, "t2_port0");
    step; HADDR = 32'h0000_0004; HTRANS = 2'b10;
    exp_sel(0, 0, 8'h01, "t2_hsel0_pending");
    step; step; step; p_ready[5] = 1'b1;
    step; HTRANS = 2'b00;

    // unmapped NONSEQ then IDLE to the same address
    step; HADDR = 32'h5000_0000; HTRANS = 2'b10;
    exp_sel(0, 0, 8'h00, "t3_hsel_none");
    exp_rsp(1, 0, 0, 1'b0, 1'b1, 32'h0, "t3_err1");
    exp_rsp(2, 0, 0, 1'b1, 1'b1, 32'h0, "t3_err2");
    exp_rsp(3, 0, 0, 1'b1, 1'b0, 32'h0, "t3_idle_unmapped");
    step; HTRANS = 2'b00;
    step; step;

    // second unmapped SEQ presented during ERR2
    step; HADDR = 32'h5000_0000; HTRANS = 2'b10;
    exp_rsp(1, 0, 0, 1'b0, 1'b1, 32'h0, "t4_err1a");
    exp_rsp(2, 0, 0, 1'b1, 1'b1, 32'h0, "t4_err2a");
    exp_rsp(3, 0, 0, 1'b0, 1'b1, 32'h0, "t4_err1b");
    exp_rsp(4, 0, 0, 1'b1, 1'b1, 32'h0, "t4_err2b");
    exp_rsp(5, 0, 0, 1'b1, 1'b0, 32'h0, "t4_idle");
    step; HADDR = 32'h5000_0004; HTRANS = 2'b11;
    step;
    step; HTRANS = 2'b00;
    step; step;

    // disabled port and overlapping windows
    step; HADDR = 32'h4000_0000; HTRANS = 2'b10;
    exp_sel(0, 0, 8'h04, "t5_a_port2");
    exp_sel(0, 1, 8'h00, "t5_b_disabled");
    exp_sel(0, 2, 8'h04, "t5_c_overlap_port2");
    exp_rsp(1, 0, 0, 1'b1, 1'b0, 32'h2222_2222, "t5_a_rdata");
    exp_rsp(1, 0, 1, 1'b0, 1'b1, 32'h0, "t5_b_err1");
    exp_rsp(1, 0, 2, 1'b1, 1'b0, 32'h2222_2222, "t5_c_rdata");
    exp_rsp(2, 0, 1, 1'b1, 1'b1, 32'h0, "t5_b_err2");
    step; HADDR = 32'h4001_0000; HTRANS = 2'b00;
    exp_sel(0, 2, 8'h08, "t5_c_port3_mask");
    exp_sel(0, 0, 8'h08, "t5_a_port3");
    step; HADDR = 32'h4003_0000;
    exp_sel(0, 2, 8'h08, "t5_c_port3_wins");
    exp_sel(0, 0, 8'h20, "t5_a_port5");

`ifdef AHB_DECODER_ERRLOG_EN
    step; err_clr = 1'b1;
    exp_err(0, 1'b1, 32'h5000_0000, "e_first_wins");
    step; err_clr = 1'b0;
    exp_err(0, 1'b0, 32'h0, "e_cleared");
    step; HADDR = 32'h6000_1234; HTRANS = 2'b10;
    exp_err(1, 1'b1, 32'h6000_1234, "e_capture");
    exp_rsp(1, 0, 0, 1'b0, 1'b1, 32'h0, "e_err1");
    step; HTRANS = 2'b00;
    step; HADDR = 32'h7000_0000; HTRANS = 2'b10;
    exp_err(1, 1'b1, 32'h6000_1234, "e_keep_first");
    exp_rsp(1, 0, 0, 1'b0, 1'b1, 32'h0, "e_second_err1");
    step; HTRANS = 2'b00;
    step;
    step; err_clr = 1'b1;
    step; err_clr = 1'b0;
    exp_err(0, 1'b0, 32'h0, "e_clr2");
`endif

    // reset asserted in ERR1 takes effect before the next clock edge
    step; HADDR = 32'h5000_0000; HTRANS = 2'b10;
    exp_rsp(1, 0, 0, 1'b0, 1'b1, 32'h0, "t6_err1");
    exp_rsp(1, 1, 0, 1'b1, 1'b0, 32'h0, "t6_async_rst");
    step; HTRANS = 2'b00;
    @(negedge HCLK); #1; HRESET = 1'b1;
    step; HADDR = 32'h2000_0000;
    exp_sel(0, 0, 8'h02, "t6_hsel_in_rst");
    exp_rsp(0, 0, 0, 1'b1, 1'b0, 32'h0, "t6_rst_held");
`ifdef AHB_DECODER_ERRLOG_EN
    exp_err(0, 1'b0, 32'h0, "t6_errlog_rst");
`endif
    step; HRESET = 1'b0;

    step; step; step;
    while (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s: never checked, expected at cycle %0d", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahblite_interconnect_n.md
Name: ahblite_interconnect_n

Overview:
- Parametrised AHB-Lite address decoder plus slave-response multiplexer for the Cortex-M0 SoC bus; successor to the fixed 7-port decoder.
- Decodes HADDR[31:16] against per-port base/mask pairs to produce one-hot P_HSEL.
- Registers the data-phase selection and returns HRDATA/HREADY/HRESP from the selected slave.
- Includes a built-in default slave that gives a two-cycle AHB ERROR response to unmapped NONSEQ/SEQ transfers.

Parameters:
- PORT_NUM, 8, number of slave ports (1..16).
- PORT_EN, 16'h00FF, per-port enable mask; bit i=0 means port i never selected.
- BASE_ADDR, {16'h4005,16'h4004,16'h4003,16'h4002,16'h4001,16'h4000,16'h2000,16'h0000}, flattened 16 bits per port (port 0 in LSBs), compared to HADDR[31:16].
- ADDR_MASK, {8{16'hFFFF}}, flattened 16 bits per port; match when (HADDR[31:16] & mask) == (base & mask).

Ports:
- HCLK  input  1  bus clock
- HRESET  input  1  asynchronous reset, active-high
- HADDR  input  32  master address (address phase)
- HTRANS  input  2  master transfer type
- HREADY  output  1  bus ready to master and to all slaves' HREADY inputs
- HRDATA  output  32  read data to master
- HRESP  output  1  response to master (0 OKAY, 1 ERROR)
- P_HSEL  output  PORT_NUM  one-hot combinational slave select (address phase)
- P_HRDATA  input  32*PORT_NUM  slave read data, flattened
- P_HREADYOUT  input  PORT_NUM  slave ready outputs
- P_HRESP  input  PORT_NUM  slave responses

Behaviour:
- Decode (combinational): port i matches if PORT_EN[i] and masked compare true. If several ports match, the lowest index wins, so P_HSEL is always one-hot or zero. P_HSEL is independent of HTRANS (slaves qualify with HTRANS/HREADY).
- Default hit: no port matches.
- Data-phase select register dsel (PORT_NUM+1 bits, one-hot, extra bit = default slave):
  - Loaded with {default_hit, P_HSEL} on rising HCLK when HREADY=1.
  - Held while HREADY=0.
  - Reset value: default-slave bit set, others 0.
- Output mux:
  - dsel = port i: HRDATA=P_HRDATA[i], HREADY=P_HREADYOUT[i], HRESP=P_HRESP[i].
  - dsel = default: HRDATA=32'h0, and HREADY/HRESP come from the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0. Go to ERR1 when HREADY=1, default_hit=1 and HTRANS[1]=1 (NONSEQ/SEQ). IDLE/BUSY to unmapped addresses stay in IDLE (zero-wait OKAY).
  - ERR1: HREADY=0, HRESP=1; always go to ERR2 next cycle.
  - ERR2: HREADY=1, HRESP=1. Then go to ERR1 if another unmapped NONSEQ/SEQ is presented this cycle, else IDLE.
  - FSM outputs matter only when dsel selects default; the FSM still advances on its own conditions regardless.
- Reset values: HREADY=1, HRESP=0, HRDATA=0, FSM=IDLE. P_HSEL follows HADDR combinationally even during reset.
- Reset asserted mid-transfer (including ERR1) returns to IDLE/default immediately and asynchronously.
- Back-to-back: address of transfer N+1 is decoded in the same cycle as data phase of N. dsel switches only on the cycle HREADY=1 completes N.
- Latency: zero added wait states for mapped slaves; exactly one wait state plus an ERROR cycle for unmapped transfers.

Optional Feature:
- Macro: AHB_DECODER_ERRLOG_EN.
- Defined: adds ports ERR_CLR (input, 1), ERR_VALID (output, 1) and ERR_ADDR (output, 32).
  - On the FSM IDLE->ERR1 transition (and ERR2->ERR1), HADDR is captured into ERR_ADDR and ERR_VALID is set (sticky).
  - The first error wins while ERR_VALID=1.
  - ERR_CLR=1 clears ERR_VALID next cycle; a simultaneous new error takes priority over the clear.
  - Both reset to 0.
- Undefined: ports and registers absent; behaviour otherwise identical.

Test Plan:
- Reset, then NONSEQ read HADDR=32'h2000_0010 with port1 HRDATA=32'hDEADBEEF, HREADYOUT=1 -> P_HSEL=8'h02 in address phase; next cycle HRDATA=32'hDEADBEEF, HREADY=1, HRESP=0.
- NONSEQ to 32'h4003_0000 with port5 holding HREADYOUT=0 for 3 cycles while the next address 32'h0000_0004 is driven -> HREADY low 3 cycles; dsel stays port5; port0 selected only after completion.
- NONSEQ to unmapped 32'h5000_0000 -> cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1, HRDATA=0; IDLE to the same address -> HREADY=1, HRESP=0.
- Two consecutive unmapped SEQ transfers (second presented in ERR2) -> ERR1, ERR2, ERR1, ERR2, then IDLE.
- PORT_EN=16'h00FB, NONSEQ to 32'h4000_0000 -> P_HSEL=0 and ERROR response; overlap test BASE port3=16'h4000 with mask 16'hF000 -> port2 wins for 32'h4000_0000.
- With AHB_DECODER_ERRLOG_EN: error at 32'h6000_1234, then at 32'h7000_0000 -> ERR_ADDR=32'h6000_1234, ERR_VALID=1; ERR_CLR pulse -> ERR_VALID=0; assert HRESET during ERR1 -> HREADY=1, HRESP=0 immediately.
